// File: rtl/gfx_pkg.sv
// Shared graphics types: colour index, signed screen coordinate, the
// transparent colour index and the line-buffer state encoding.
package gfx_pkg;

  localparam int COLR_BITS = 4;
  localparam int CORDW     = 16;

  typedef logic [COLR_BITS-1:0]    colr_t;
  typedef logic signed [CORDW-1:0] cord_t;

  // Colour index meaning "no sprite pixel here".
  localparam colr_t TRANSP = '0;

  typedef enum logic {
    CLEAR,
    RUN
  } lb_state_t;

endpackage

// File: rtl/linebuf_bank.sv
// One scanline bank: simple dual-port RAM with a registered, read-first
// read port and a single write port.
module linebuf_bank #(
  parameter int DEPTH = 640,
  parameter int WIDTH = gfx_pkg::COLR_BITS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write and registered read in one process; a same-address access returns the old word.
  // NOTE: the RAM and its read register have no reset so this maps onto block RAM;
  // the top wipes the contents itself and gates the read data until it is valid.
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/sprite_linebuf.sv
// Double-buffered sprite scanline buffer: captures the sprite engine's pixels
// into the write bank during one line and replays them, composited over the
// background colour, during the next.
module sprite_linebuf #(
  parameter int                   LINE_W    = 640,
  parameter int                   COLR_BITS = gfx_pkg::COLR_BITS,
  parameter int                   CORDW     = gfx_pkg::CORDW,
  parameter logic [COLR_BITS-1:0] TRANSP    = gfx_pkg::TRANSP,
  parameter int                   WR_OFS    = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_line,
  input  logic signed [CORDW-1:0] i_sx,
  input  logic                    i_drawing,
  input  logic [COLR_BITS-1:0]    i_pix,
  input  logic [COLR_BITS-1:0]    i_bg,
  output logic [COLR_BITS-1:0]    o_pix,
  output logic                    o_hit,
  output logic                    o_ready,
  output logic                    o_bank
);

  import gfx_pkg::*;

  localparam int                      AW        = $clog2(LINE_W);
  localparam logic signed [CORDW-1:0] LINE_W_C  = CORDW'(LINE_W);
  localparam logic signed [CORDW-1:0] WR_OFS_C  = CORDW'(WR_OFS);
  localparam logic [AW-1:0]           LAST_ADDR = AW'(LINE_W - 1);

  lb_state_t               state, state_nx;
  logic [AW-1:0]           clr_addr;
  logic signed [CORDW-1:0] wa;
  logic                    wa_ok, ra_ok, spr_we;
  logic                    rd_ok_r, rd_bank_r;
  logic [COLR_BITS-1:0]    bg_r, q;

  logic                    bank_we    [2];
  logic [AW-1:0]           bank_waddr [2];
  logic [COLR_BITS-1:0]    bank_wdata [2];
  logic [COLR_BITS-1:0]    bank_q     [2];

  // Address decode: both addresses are range-checked as signed values, never wrapped.
  always_comb begin
    wa     = i_sx + WR_OFS_C;
    wa_ok  = !wa[CORDW-1] && (wa < LINE_W_C);
    ra_ok  = !i_sx[CORDW-1] && (i_sx < LINE_W_C);
    spr_we = i_drawing && (i_pix != TRANSP) && wa_ok;
  end

  // State register and clear-address counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state <= state_nx;
      if (state == CLEAR && clr_addr != LAST_ADDR) clr_addr <= clr_addr + 1'b1;
    end
  end

  // Next state: leave CLEAR once the last address of both banks has been wiped.
  always_comb begin
    state_nx = state;
    if (state == CLEAR && clr_addr == LAST_ADDR) state_nx = RUN;
  end

  // Bank write-port steering: clear write, else read-clear on the read bank and sprite write on the other.
  always_comb begin
    // NOTE: every output gets a default first so no path through this block infers a latch.
    for (int b = 0; b < 2; b++) begin
      bank_we[b]    = 1'b0;
      bank_waddr[b] = clr_addr;
      bank_wdata[b] = TRANSP;
    end
    if (state == CLEAR) begin
      for (int b = 0; b < 2; b++) bank_we[b] = 1'b1;
    end else begin
      bank_we[o_bank]     = ra_ok;
      bank_waddr[o_bank]  = i_sx[AW-1:0];
      bank_we[~o_bank]    = spr_we;
      bank_waddr[~o_bank] = wa[AW-1:0];
      bank_wdata[~o_bank] = i_pix;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    linebuf_bank #(
      .DEPTH (LINE_W),
      .WIDTH (COLR_BITS),
      .AW    (AW)
    ) u_bank (
      .i_clk   (i_clk),
      .i_we    (bank_we[g]),
      .i_waddr (bank_waddr[g]),
      .i_wdata (bank_wdata[g]),
      .i_raddr (i_sx[AW-1:0]),
      .o_rdata (bank_q[g])
    );
  end

  // Bank swap, ready flag and the read-side pipeline register aligned with the RAM read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_bank    <= 1'b0;
      o_ready   <= 1'b0;
      rd_ok_r   <= 1'b0;
      rd_bank_r <= 1'b0;
      bg_r      <= '0;
    end else begin
      o_ready   <= (state == RUN);
      if (state == RUN && i_line) o_bank <= ~o_bank;
      rd_ok_r   <= (state == RUN) && ra_ok;
      rd_bank_r <= o_bank;
      bg_r      <= i_bg;
    end
  end

  // Composite: sprite pixel when the read was valid and non-transparent, else background.
  always_comb begin
    q     = bank_q[rd_bank_r];
    o_hit = rd_ok_r && (q != TRANSP);
    o_pix = o_hit ? q : bg_r;
  end

endmodule

// File: tb/tb_sprite_linebuf.sv
// Directed bench for sprite_linebuf: clear timing, capture/replay,
// transparency and overlap, range limits, bank-swap timing, mid-line reset.
module tb_sprite_linebuf;

  localparam int LINE_W = 640;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_line;
  logic signed [15:0] i_sx;
  logic               i_drawing;
  logic [3:0]         i_pix;
  logic [3:0]         i_bg;
  logic [3:0]         o_pix;
  logic               o_hit;
  logic               o_ready;
  logic               o_bank;

  int         errors = 0;
  int         checks = 0;
  int         n;
  logic [3:0] exp_line [LINE_W];

  always #5 i_clk = ~i_clk;

  sprite_linebuf #(
    .LINE_W    (LINE_W),
    .COLR_BITS (4),
    .CORDW     (16),
    .TRANSP    (4'd0),
    .WR_OFS    (0)
  ) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_line    (i_line),
    .i_sx      (i_sx),
    .i_drawing (i_drawing),
    .i_pix     (i_pix),
    .i_bg      (i_bg),
    .o_pix     (o_pix),
    .o_hit     (o_hit),
    .o_ready   (o_ready),
    .o_bank    (o_bank)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input int sx, input bit drawing, input int pix, input bit line, input int bg);
    i_sx      = 16'(sx);
    i_drawing = drawing;
    i_pix     = 4'(pix);
    i_line    = line;
    i_bg      = 4'(bg);
    @(posedge i_clk);
    #1;
  endtask

  // Read x=lo..hi and compare against the expected line; reading empties the model entry.
  task automatic sweep(input int bg, input int lo, input int hi, input string tag);
    for (int x = lo; x <= hi; x++) begin
      cyc(x, 1'b0, 0, 1'b0, bg);
      check($sformatf("%s pix x=%0d", tag, x), o_pix,
            (exp_line[x] != 4'd0) ? int'(exp_line[x]) : bg);
      check($sformatf("%s hit x=%0d", tag, x), o_hit, int'(exp_line[x] != 4'd0));
      exp_line[x] = 4'd0;
    end
  endtask

  // Wait for o_ready with a cycle bound; optionally poke sprite writes and line pulses
  // during the clear and verify they have no effect.
  task automatic wait_ready(input bit watch, output int cycles);
    cycles = 0;
    while (!o_ready && cycles < 2000) begin
      cyc((watch && cycles < 600) ? 5 : -1, watch && cycles < 600, 7,
          watch && (cycles == 100 || cycles == 300), 5);
      cycles++;
      if (watch && cycles <= 640) begin
        check($sformatf("clear pix c=%0d", cycles), o_pix, 5);
        check($sformatf("clear hit c=%0d", cycles), o_hit, 0);
        check($sformatf("clear bank c=%0d", cycles), o_bank, 0);
      end
    end
    check("ready before timeout", o_ready, 1);
  endtask

  initial begin
    foreach (exp_line[i]) exp_line[i] = 4'd0;

    // Reset state.
    i_rst = 1'b1;
    repeat (3) cyc(-1, 1'b0, 0, 1'b0, 5);
    check("reset pix", o_pix, 0);
    check("reset hit", o_hit, 0);
    check("reset ready", o_ready, 0);
    check("reset bank", o_bank, 0);

    // Clear takes LINE_W cycles, ready follows one cycle later.
    i_rst = 1'b0;
    wait_ready(1'b1, n);
    check("ready latency", n, 641);
    check("bank after clear", o_bank, 0);

    // Capture a run of 7s, replay, then confirm both banks read empty afterwards.
    for (int x = 10; x <= 17; x++) begin
      cyc(x, 1'b1, 7, 1'b0, 2);
      exp_line[x] = 4'd7;
    end
    cyc(-1, 1'b0, 0, 1'b1, 2);
    check("swap to 1", o_bank, 1);
    sweep(2, 0, 639, "line");
    cyc(-1, 1'b0, 0, 1'b1, 2);
    check("swap to 0", o_bank, 0);
    sweep(2, 0, 639, "other");
    cyc(-1, 1'b0, 0, 1'b1, 2);
    check("swap back to 1", o_bank, 1);
    sweep(2, 0, 639, "cleared");

    // Transparent pixels never write; last opaque write wins; no write without drawing.
    cyc(20, 1'b1, 3, 1'b0, 4);
    cyc(20, 1'b1, 0, 1'b0, 4);
    cyc(21, 1'b1, 4, 1'b0, 4);
    cyc(21, 1'b1, 9, 1'b0, 4);
    cyc(22, 1'b0, 5, 1'b0, 4);
    exp_line[20] = 4'd3;
    exp_line[21] = 4'd9;
    cyc(-1, 1'b0, 0, 1'b1, 4);
    check("overlap bank", o_bank, 0);
    sweep(4, 0, 63, "overlap");

    // Out-of-range writes are dropped, including ones whose low bits alias address 0.
    cyc(-3, 1'b1, 6, 1'b0, 4);
    cyc(639, 1'b1, 6, 1'b0, 4);
    cyc(640, 1'b1, 6, 1'b0, 4);
    cyc(0, 1'b1, 6, 1'b0, 4);
    cyc(1024, 1'b1, 13, 1'b0, 4);
    cyc(-1024, 1'b1, 14, 1'b0, 4);
    exp_line[639] = 4'd6;
    exp_line[0]   = 4'd6;
    cyc(-1, 1'b0, 0, 1'b1, 4);
    check("range bank", o_bank, 1);
    // Out-of-range reads give background and must not touch address 0.
    cyc(-1, 1'b0, 0, 1'b0, 11);
    check("read -1 pix", o_pix, 11);
    check("read -1 hit", o_hit, 0);
    cyc(700, 1'b0, 0, 1'b0, 11);
    check("read 700 pix", o_pix, 11);
    check("read 700 hit", o_hit, 0);
    cyc(640, 1'b0, 0, 1'b0, 11);
    check("read 640 pix", o_pix, 11);
    cyc(1024, 1'b0, 0, 1'b0, 11);
    check("read 1024 pix", o_pix, 11);
    check("read 1024 hit", o_hit, 0);
    cyc(-1024, 1'b0, 0, 1'b0, 11);
    check("read -1024 pix", o_pix, 11);
    sweep(4, 0, 639, "range");

    // A write in the i_line cycle lands in the bank that becomes readable now.
    cyc(100, 1'b1, 12, 1'b1, 4);
    check("simul bank", o_bank, 0);
    cyc(101, 1'b1, 13, 1'b0, 4);
    exp_line[100] = 4'd12;
    sweep(4, 0, 639, "simul old");
    cyc(-1, 1'b0, 0, 1'b1, 4);
    check("simul bank next", o_bank, 1);
    exp_line[101] = 4'd13;
    sweep(4, 0, 639, "simul new");

    // Reset in mid-sweep with data still pending in the read bank.
    for (int x = 300; x <= 305; x++) begin
      cyc(x, 1'b1, 8, 1'b0, 3);
      exp_line[x] = 4'd8;
    end
    cyc(-1, 1'b0, 0, 1'b1, 3);
    check("pre-reset bank", o_bank, 0);
    sweep(3, 0, 300, "pre-reset");
    #2 i_rst = 1'b1;
    #1;
    check("mid reset pix", o_pix, 0);
    check("mid reset hit", o_hit, 0);
    check("mid reset ready", o_ready, 0);
    check("mid reset bank", o_bank, 0);
    cyc(-1, 1'b0, 0, 1'b0, 3);
    cyc(-1, 1'b0, 0, 1'b0, 3);
    i_rst = 1'b0;
    wait_ready(1'b0, n);
    check("ready latency again", n, 641);
    foreach (exp_line[i]) exp_line[i] = 4'd0;
    sweep(3, 0, 639, "post bank0");
    cyc(-1, 1'b0, 0, 1'b1, 3);
    check("post bank", o_bank, 1);
    sweep(3, 0, 639, "post bank1");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_linebuf.md
Name: sprite_linebuf

Overview:
- Double-buffered scanline buffer directly downstream of the sprite drawing engine.
- During line N it captures the engine's pixel stream (o_pix/o_drawing) into the write bank, indexed by screen x.
- During line N+1 it replays that bank in step with the display x counter, composited over a background colour.
- It is the only path from sprite pixels to the display colour mux.

Parameters:
- LINE_W, 640, visible pixels per line (bank depth)
- COLR_BITS, 4, bits per pixel index
- CORDW, 16, screen coordinate width (signed)
- TRANSP, 0, colour index treated as transparent / empty
- WR_OFS, 0, signed offset added to i_sx to form the write address (aligns the engine's pipeline)

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-high reset
- i_line  in  1  one-cycle pulse at start of each line (bank swap)
- i_sx  in  CORDW signed  current horizontal screen position
- i_drawing  in  1  sprite engine is outputting a pixel
- i_pix  in  COLR_BITS  sprite pixel colour
- i_bg  in  COLR_BITS  background colour for empty/out-of-range pixels
- o_pix  out  COLR_BITS  composited colour for display
- o_hit  out  1  o_pix came from a sprite pixel
- o_ready  out  1  initial clear complete
- o_bank  out  1  index of current read bank

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: o_pix=0, o_hit=0, o_ready=0, o_bank=0, state=CLEAR, clear address=0. RAM contents are not reset.
- States:
  - CLEAR: write TRANSP to address clr_addr in both banks every cycle, clr_addr 0..LINE_W-1. After writing LINE_W-1, go to RUN and set o_ready=1 the next cycle. Takes exactly LINE_W cycles.
  - RUN: normal operation; leaves only on reset.
- During CLEAR: sprite writes ignored, i_line ignored (o_bank stays 0), o_pix=i_bg registered, o_hit=0.
- Banks: read bank = o_bank, write bank = !o_bank. On an i_line pulse in RUN, o_bank toggles at that clock edge.
  - Any write or read in the same cycle as i_line uses the pre-toggle banks.
- Write path (RUN):
  - wa = i_sx + WR_OFS, computed CORDW wide, signed.
  - Write i_pix to write bank[wa] iff i_drawing && i_pix != TRANSP && 0 <= wa < LINE_W.
  - Otherwise no write; out-of-range addresses are silently dropped with no wrap.
  - Later writes to the same address overwrite earlier ones (last sprite wins).
- Read path (RUN): ra = i_sx.
  - If 0 <= ra < LINE_W: read bank[ra] into q. In the same cycle, write TRANSP to read bank[ra] (read-and-clear, old data returned).
  - Else q = TRANSP and no clear.
- Output: registered, 1-cycle latency from i_sx.
  - o_pix = (q != TRANSP) ? q : i_bg, with i_bg sampled in the same cycle as i_sx.
  - o_hit = (q != TRANSP).
- A bank is fully cleared after one complete read sweep of x=0..LINE_W-1. Lines where the display never reaches an address leave stale data, which the display timing guarantees will not occur.
- Reset asserted mid-line: outputs return to reset values immediately. The next release re-enters CLEAR, and both banks are wiped before o_ready.
- Widths: compare signed CORDW against LINE_W extended to CORDW; negative values are out of range.
- Storage: each bank is one RAM with one read and one write port. The write-port mux priority is CLEAR write, then read-clear on the read bank, then sprite write on the write bank; these never target the same bank in RUN.

Decomposition:
- Shared package gfx_pkg: colour index typedef (COLR_BITS), signed coordinate typedef (CORDW), TRANSP constant, linebuf state enum {CLEAR, RUN}.
- One sub-module, linebuf_bank: simple dual-port RAM, LINE_W x COLR_BITS, registered read, one write port. Instantiated twice.

Test Plan:
- Reset release, LINE_W=640 -> o_ready rises exactly 641 cycles after release. Until then o_pix=i_bg=5, o_hit=0, and i_line pulses leave o_bank=0.
- Line N: write i_pix=7 at sx=10..17 (drawing=1), i_line, then sweep sx=0..639 with i_bg=2 -> o_pix=7/o_hit=1 one cycle after sx=10..17, 2 elsewhere. A second identical sweep after the next i_line (no writes) -> all 2 (clear-on-read verified).
- Transparency/overlap: write 3 at sx=20, then TRANSP(0) at sx=20, then 9 at sx=21 twice (values 4 then 9) -> replay gives sx=20:3, sx=21:9.
- Range: WR_OFS=0, writes at sx=-3, 639, 640 with pix=6 -> only address 639 shows 6. Read at sx=-1 and 700 -> o_pix=i_bg, o_hit=0.
- Simultaneous: write at sx=100 in the same cycle as i_line -> lands in old write bank, so it is visible on the line just starting. A write the next cycle goes to the new write bank.
- Reset mid-sweep at sx=300 with pending data -> o_pix=0 immediately. After CLEAR, replay shows only i_bg.
